// File: rtl/cpu_seq_ctrl_pkg.sv
// Sequencer constants: state encodings, reset PC and NOP encoding.
// Shared by the multi-cycle control and its bench.
package cpu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    SEQ_IF   = 3'd0,
    SEQ_ID   = 3'd1,
    SEQ_EX   = 3'd2,
    SEQ_MEM  = 3'd3,
    SEQ_WB   = 3'd4,
    SEQ_HALT = 3'd5
  } seq_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_8000;
  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;

endpackage

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle RV32I sequencer: owns pc, ir and instret, and steps
// each instruction through IF/ID/EX/MEM/WB with memory handshakes.
module cpu_seq_ctrl
  import cpu_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_reg_we,
  input  logic        dec_is_halt,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        halted,
  output logic [31:0] instret
);

  seq_state_t  state;
  seq_state_t  state_nxt;
  logic        started;
  logic        tk_q;
  logic [31:0] tgt_q;
  logic        fetch_done;

  // started holds off the first fetch until one edge after reset
  assign fetch_done = (state == SEQ_IF) & started & imem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SEQ_IF;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SEQ_IF:   if (fetch_done) state_nxt = SEQ_ID;
      SEQ_ID:   state_nxt = dec_is_halt ? SEQ_HALT : SEQ_EX;
      SEQ_EX: begin
        if (dec_is_load || dec_is_store)
          state_nxt = SEQ_MEM;
        else
          state_nxt = SEQ_WB;
      end
      SEQ_MEM:  if (dmem_ready) state_nxt = SEQ_WB;
      SEQ_WB:   state_nxt = SEQ_IF;
      SEQ_HALT: state_nxt = SEQ_HALT;
      default:  state_nxt = SEQ_IF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= NOP_INSN;
      tk_q    <= 1'b0;
      tgt_q   <= 32'd0;
      instret <= 32'd0;
    end else begin
      if (fetch_done)
        ir <= imem_rdata;
      if (state == SEQ_EX) begin
        tk_q  <= br_taken;
        tgt_q <= br_target & ~32'd3;
      end
      if (state == SEQ_WB) begin
        pc      <= tk_q ? tgt_q : pc + 32'd4;
        instret <= instret + 32'd1;
      end
    end
  end

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    unique case (state)
      SEQ_IF:   imem_req = started;
      SEQ_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_is_store;
      end
      SEQ_WB:   rf_we = dec_reg_we & ~dec_is_store;
      SEQ_HALT: halted = 1'b1;
      default:  ;
    endcase
  end

  assign imem_addr = pc;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: acts as instruction/data memory and decoder,
// predicting phase lengths and architectural state per instruction.
module tb_cpu_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_8000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] ir;
  logic        dec_is_load = 1'b0;
  logic        dec_is_store = 1'b0;
  logic        dec_reg_we = 1'b0;
  logic        dec_is_halt = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready = 1'b0;
  logic        rf_we;
  logic [31:0] pc;
  logic        halted;
  logic [31:0] instret;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] exp_ret = 32'd0;

  cpu_seq_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ir(ir),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_reg_we(dec_reg_we), .dec_is_halt(dec_is_halt),
    .br_taken(br_taken), .br_target(br_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ready(dmem_ready),
    .rf_we(rf_we), .pc(pc), .halted(halted),
    .instret(instret)
  );

  always #5 clk = ~clk;

  // One instruction from its first IF cycle to the next IF (or HALT).
  task automatic run_instr(
    input logic [31:0] insn,
    input logic ld, input logic st, input logic we,
    input logic hlt, input logic tk,
    input logic [31:0] tgt,
    input int iw, input int dw, input string nm
  );
    int k = 0;
    int ireq = 0;
    int dreq = 0;
    int rfw = 0;
    int rfw_at = -1;
    int dwe_bad = 0;
    int ic = 0;
    int dc = 0;
    bit seen_low = 0;
    bit done = 0;
    int exp_len;
    int exp_dreq;
    int exp_rfw;
    dec_is_load = ld;
    dec_is_store = st;
    dec_reg_we = we;
    dec_is_halt = hlt;
    imem_rdata = insn;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
      bad++;
      $display("FAIL %s start: req=%b addr=%h want 1 %h",
               nm, imem_req, imem_addr, exp_pc);
    end
    while (!done && k < 200) begin
      if (imem_req) begin
        ireq++;
        imem_ready = (ic == iw);
        ic++;
      end else imem_ready = 1'($urandom);
      if (dmem_req) begin
        dreq++;
        if (dmem_we !== st) dwe_bad++;
        dmem_ready = (dc == dw);
        dc++;
      end else dmem_ready = 1'($urandom);
      if (rf_we) begin
        rfw++;
        rfw_at = k;
      end
      if (k == iw + 2) begin
        br_taken = tk;
        br_target = tgt;
      end else begin
        br_taken = 1'($urandom);
        br_target = $urandom;
      end
      k++;
      @(negedge clk);
      if (!imem_req) seen_low = 1;
      if ((imem_req && seen_low) || halted) done = 1;
    end
    if (hlt) exp_len = iw + 2;
    else exp_len = iw + 4 + ((ld | st) ? dw + 1 : 0);
    exp_dreq = (!hlt && (ld | st)) ? dw + 1 : 0;
    exp_rfw = (!hlt && we && !st) ? 1 : 0;
    if (!hlt) begin
      exp_pc = tk ? {tgt[31:2], 2'b00} : exp_pc + 32'd4;
      exp_ret = exp_ret + 32'd1;
    end
    total++;
    if (k !== exp_len) begin
      bad++;
      $display("FAIL %s len: got %0d want %0d", nm, k, exp_len);
    end
    total++;
    if (ireq !== iw + 1) begin
      bad++;
      $display("FAIL %s imem_req cycles: got %0d want %0d",
               nm, ireq, iw + 1);
    end
    total++;
    if (dreq !== exp_dreq || dwe_bad !== 0) begin
      bad++;
      $display("FAIL %s dmem_req: got %0d/%0d want %0d/0",
               nm, dreq, dwe_bad, exp_dreq);
    end
    total++;
    if (rfw !== exp_rfw || rfw_at !== (exp_rfw ? exp_len - 1 : -1)) begin
      bad++;
      $display("FAIL %s rf_we: got %0d@%0d want %0d", nm, rfw, rfw_at, exp_rfw);
    end
    total++;
    if (pc !== exp_pc || instret !== exp_ret) begin
      bad++;
      $display("FAIL %s arch: pc=%h ret=%0d want %h %0d",
               nm, pc, instret, exp_pc, exp_ret);
    end
    total++;
    if (ir !== insn || halted !== hlt) begin
      bad++;
      $display("FAIL %s ir/halt: got %h %b want %h %b",
               nm, ir, halted, insn, hlt);
    end
    if (!hlt) begin
      total++;
      if (imem_addr !== exp_pc) begin
        bad++;
        $display("FAIL %s next addr: got %h want %h", nm, imem_addr, exp_pc);
      end
    end
  endtask

  task automatic check_reset_state(input string nm);
    total++;
    if (pc !== RST_PC || instret !== 32'd0 || ir !== NOP ||
        halted !== 1'b0 || imem_req !== 1'b0 ||
        dmem_req !== 1'b0 || rf_we !== 1'b0) begin
      bad++;
      $display("FAIL %s: pc=%h ret=%0d ir=%h h=%b ireq=%b dreq=%b rfwe=%b",
               nm, pc, instret, ir, halted, imem_req, dmem_req, rf_we);
    end
  endtask

  task automatic release_reset(input string nm);
    rst = 1'b0;
    #1;
    check_reset_state({nm, " released"});
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1) begin
      bad++;
      $display("FAIL %s imem_req rise: got %b want 1", nm, imem_req);
    end
    exp_pc = RST_PC;
    exp_ret = 32'd0;
  endtask

  task automatic test_reset;
    imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("reset held");
    release_reset("reset");
  endtask

  task automatic test_addi;
    run_instr(32'h0010_0093, 0, 0, 1, 0, 0, 32'd0, 0, 0, "addi");
  endtask

  task automatic test_load_waits;
    run_instr(32'h0000_a083, 1, 0, 1, 0, 0, 32'd0, 2, 3, "load");
  endtask

  task automatic test_store;
    run_instr(32'h0010_a023, 0, 1, 1, 0, 0, 32'd0, 1, 1, "store");
  endtask

  task automatic test_branch;
    run_instr(32'h0000_006f, 0, 0, 0, 0, 1, 32'h0000_8013, 0, 0, "branch");
  endtask

  task automatic test_wrap;
    run_instr(32'h0000_006f, 0, 0, 1, 0, 1, 32'hFFFF_FFFE, 0, 0, "to_top");
    run_instr(32'h0000_0063, 0, 0, 0, 0, 0, 32'h0000_1234, 0, 0, "wrap");
  endtask

  task automatic test_random;
    for (int n = 0; n < 30; n++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      run_instr($urandom, kind == 1, kind == 2, 1'($urandom), 0,
                1'($urandom), $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                "random");
    end
  endtask

  task automatic test_reset_mid_mem;
    int k = 0;
    dec_is_load = 1'b1;
    dec_is_store = 1'b0;
    dec_is_halt = 1'b0;
    dec_reg_we = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    while (!dmem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (dmem_req !== 1'b1) begin
      bad++;
      $display("FAIL midmem reach: dmem_req never rose in %0d cycles", k);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (dmem_req !== 1'b0 || imem_req !== 1'b0 || rf_we !== 1'b0) begin
      bad++;
      $display("FAIL midmem drop: dreq=%b ireq=%b rfwe=%b want 0 0 0",
               dmem_req, imem_req, rf_we);
    end
    @(negedge clk);
    check_reset_state("midmem held");
    release_reset("midmem");
  endtask

  task automatic test_halt;
    logic [31:0] pc0;
    logic [31:0] ret0;
    run_instr(32'h0010_0073, 0, 0, 1, 1, 0, 32'd0, 1, 0, "halt");
    pc0 = exp_pc;
    ret0 = exp_ret;
    for (int n = 0; n < 20; n++) begin
      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      @(negedge clk);
      total++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || dmem_req !== 1'b0 ||
          rf_we !== 1'b0 || pc !== pc0 || instret !== ret0) begin
        bad++;
        $display("FAIL halt hold %0d: h=%b ireq=%b dreq=%b pc=%h ret=%0d",
                 n, halted, imem_req, dmem_req, pc, instret);
      end
    end
  endtask

  initial begin
    test_reset;
    test_addi;
    test_load_waits;
    test_store;
    test_branch;
    test_wrap;
    test_random;
    test_reset_mid_mem;
    test_addi;
    test_halt;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
